md_unit: RTL and testbench

//  E-stage multiply/divide unit for the pipelined MIPS core: executes mult/multu/div/divu,

---
 rtl/md_unit_pkg.sv | 24 ++
 rtl/md_unit.sv | 120 ++++++++++++
 tb/tb_md_unit.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/md_unit_pkg.sv
// Shared definitions for the multiply/divide unit: MDOp encodings and decode helpers.
package md_unit_pkg;

  typedef enum logic [3:0] {
    MdNone  = 4'd0,
    MdMult  = 4'd1,
    MdMultu = 4'd2,
    MdDiv   = 4'd3,
    MdDivu  = 4'd4,
    MdMfhi  = 4'd5,
    MdMflo  = 4'd6,
    MdMthi  = 4'd7,
    MdMtlo  = 4'd8
  } md_op_e;

  function automatic logic is_launch_op(md_op_e op);
    return (op == MdMult) || (op == MdMultu) || (op == MdDiv) || (op == MdDivu);
  endfunction

  function automatic logic is_div_op(md_op_e op);
    return (op == MdDiv) || (op == MdDivu);
  endfunction

endpackage

// File: rtl/md_unit.sv
// E-stage multiply/divide unit: owns HI/LO, models fixed mult/div latency with a busy counter.
module md_unit
  import md_unit_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  MDOp,
  input  logic        Start,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic [31:0] HI_out,
  output logic [31:0] LO_out,
  output logic [31:0] MD_out
);

  md_op_e op;
  assign op = md_op_e'(MDOp);

  logic        busy_q, busy_d;
  logic        commit_q, commit_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] hi_tmp_q, hi_tmp_d, lo_tmp_q, lo_tmp_d;

  logic signed [63:0] a_sx, b_sx, prod_s;
  logic        [63:0] prod_u;
  logic signed [31:0] a_s, b_s, quot_s, rem_s;
  logic        [31:0] b_u, quot_u, rem_u;
  logic               div_ovf, div_zero;

  always_comb begin
    a_sx     = {{32{A[31]}}, A};
    b_sx     = {{32{B[31]}}, B};
    prod_s   = a_sx * b_sx;
    prod_u   = {32'h0, A} * {32'h0, B};
    div_zero = (B == 32'h0);
    div_ovf  = (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);
    // Substitute a divisor of 1 so the operators never see the undefined cases.
    a_s      = A;
    b_s      = (div_zero || div_ovf) ? 32'sd1 : B;
    b_u      = div_zero ? 32'd1 : B;
    quot_s   = div_ovf ? 32'sh8000_0000 : a_s / b_s;
    rem_s    = div_ovf ? 32'sd0 : a_s % b_s;
    quot_u   = A / b_u;
    rem_u    = A % b_u;
  end

  always_comb begin
    busy_d   = busy_q;
    commit_d = commit_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    hi_tmp_d = hi_tmp_q;
    lo_tmp_d = lo_tmp_q;
    if (busy_q) begin
      if (cnt_q == 32'd1) begin
        busy_d = 1'b0;
        cnt_d  = 32'd0;
        if (commit_q) begin
          hi_d = hi_tmp_q;
          lo_d = lo_tmp_q;
        end
      end else begin
        cnt_d = cnt_q - 32'd1;
      end
    end else if (Start && is_launch_op(op)) begin
      busy_d   = 1'b1;
      cnt_d    = is_div_op(op) ? DIV_CYCLES : MULT_CYCLES;
      commit_d = !(is_div_op(op) && div_zero);
      case (op)
        MdMult:  {hi_tmp_d, lo_tmp_d} = prod_s;
        MdMultu: {hi_tmp_d, lo_tmp_d} = prod_u;
        MdDiv:   {hi_tmp_d, lo_tmp_d} = {rem_s, quot_s};
        default: {hi_tmp_d, lo_tmp_d} = {rem_u, quot_u};
      endcase
    end else if (op == MdMthi) begin
      hi_d = A;
    end else if (op == MdMtlo) begin
      lo_d = A;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      busy_q   <= 1'b0;
      commit_q <= 1'b0;
      cnt_q    <= 32'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      hi_tmp_q <= 32'd0;
      lo_tmp_q <= 32'd0;
    end else begin
      busy_q   <= busy_d;
      commit_q <= commit_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      hi_tmp_q <= hi_tmp_d;
      lo_tmp_q <= lo_tmp_d;
    end
  end

  assign Busy   = busy_q;
  assign HI_out = hi_q;
  assign LO_out = lo_q;

  always_comb begin
    case (op)
      MdMfhi:  MD_out = hi_q;
      MdMflo:  MD_out = lo_q;
      default: MD_out = 32'h0;
    endcase
  end

endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: stimulus pushes expected HI/LO/busy length, monitor checks on Busy fall.
module tb_md_unit;

  logic        clk;
  logic        reset;
  logic [3:0]  MDOp;
  logic        Start;
  logic [31:0] A, B;
  logic        Busy;
  logic [31:0] HI_out, LO_out, MD_out;

  localparam logic [3:0] OpNone = 4'd0, OpMult = 4'd1, OpMultu = 4'd2, OpDiv = 4'd3,
                         OpDivu = 4'd4, OpMfhi = 4'd5, OpMflo = 4'd6, OpMthi = 4'd7,
                         OpMtlo = 4'd8;

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk    (clk),
    .reset  (reset),
    .MDOp   (MDOp),
    .Start  (Start),
    .A      (A),
    .B      (B),
    .Busy   (Busy),
    .HI_out (HI_out),
    .LO_out (LO_out),
    .MD_out (MD_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          len;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h", name, act, exp);
  endtask

  // Monitor: counts busy cycles and checks HI/LO in the first idle cycle after Busy falls.
  int   busy_len  = 0;
  logic busy_prev = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (Busy === 1'b1) begin
      busy_len++;
    end else if (busy_prev) begin
      if (exp_q.size() == 0) begin
        check32("unexpected_completion", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check32("result_hi", HI_out, e.hi);
        check32("result_lo", LO_out, e.lo);
        check32("busy_len", busy_len, e.len);
      end
      busy_len = 0;
    end
    busy_prev = (Busy === 1'b1);
  end

  task automatic launch(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] hi, input logic [31:0] lo, input int len);
    exp_t e;
    @(posedge clk); #1;
    MDOp = op; Start = 1'b1; A = a; B = b;
    e.hi = hi; e.lo = lo; e.len = len;
    exp_q.push_back(e);
    @(posedge clk); #1;
    MDOp = OpNone; Start = 1'b0; A = 32'h0; B = 32'h0;
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 40 && Busy; i++) @(negedge clk);
    check32(name, Busy, 1'b0);
  endtask

  task automatic write_hilo(input logic [3:0] op, input logic [31:0] val);
    @(posedge clk); #1;
    MDOp = op; A = val;
    @(posedge clk); #1;
    MDOp = OpNone; A = 32'h0;
  endtask

  initial begin
    reset = 1'b0; MDOp = OpNone; Start = 1'b0; A = 32'h0; B = 32'h0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check32("reset_busy", Busy, 1'b0);
    check32("reset_hi", HI_out, 32'h0);
    check32("reset_lo", LO_out, 32'h0);

    // Multiply: signed and unsigned on the same operands, plus corner products.
    launch(OpMult, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5);
    wait_idle("idle_mult");
    launch(OpMultu, 32'hFFFF_FFFE, 32'd3, 32'h0000_0002, 32'hFFFF_FFFA, 5);
    wait_idle("idle_multu");
    launch(OpMult, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 5);
    wait_idle("idle_mult_m1");
    launch(OpMultu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 5);
    wait_idle("idle_multu_max");

    // Divide: sign handling, overflow, unsigned.
    launch(OpDiv, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
    wait_idle("idle_div");
    launch(OpDiv, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 10);
    wait_idle("idle_div_negb");
    launch(OpDiv, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 10);
    wait_idle("idle_div_ovf");
    launch(OpDivu, 32'hFFFF_FFFF, 32'h10, 32'h0000_000F, 32'h0FFF_FFFF, 10);
    wait_idle("idle_divu");

    // Divide by zero leaves preset HI/LO untouched after a full busy period.
    write_hilo(OpMthi, 32'hAAAA_5555);
    write_hilo(OpMtlo, 32'h0F0F_0F0F);
    launch(OpDivu, 32'd7, 32'd0, 32'hAAAA_5555, 32'h0F0F_0F0F, 10);
    wait_idle("idle_divu_zero");

    // Start during busy cycle 2 is ignored.
    launch(OpMult, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5);
    @(posedge clk); #1;
    MDOp = OpDiv; Start = 1'b1; A = 32'd100; B = 32'd7;
    @(posedge clk); #1;
    MDOp = OpNone; Start = 1'b0; A = 32'h0; B = 32'h0;
    wait_idle("idle_mult_ignored");

    // Reset in busy cycle 4 aborts the divide and clears HI/LO.
    launch(OpDiv, 32'd100, 32'd7, 32'h0, 32'h0, 4);
    repeat (3) begin
      @(posedge clk); #1;
    end
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check32("abort_busy", Busy, 1'b0);
    repeat (12) @(negedge clk);
    check32("abort_late_busy", Busy, 1'b0);
    check32("abort_late_hi", HI_out, 32'h0);
    check32("abort_late_lo", LO_out, 32'h0);

    // mthi/mtlo then mfhi/mflo through MD_out.
    write_hilo(OpMthi, 32'h1234_5678);
    write_hilo(OpMtlo, 32'h9ABC_DEF0);
    MDOp = OpMfhi; #1;
    check32("mfhi_md_out", MD_out, 32'h1234_5678);
    check32("mfhi_hi_out", HI_out, 32'h1234_5678);
    MDOp = OpMflo; #1;
    check32("mflo_md_out", MD_out, 32'h9ABC_DEF0);
    MDOp = OpNone; #1;
    check32("none_md_out", MD_out, 32'h0);

    repeat (3) @(posedge clk);
    check32("scoreboard_empty", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
